// File: rtl/uart_tx_frame.sv
// UART transmit framer driven by an external bit-timing pulse, plus the matching
// baud-rate generator that produces that pulse while bps_start is high.

module uart_bps_gen #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic rst,
    input  logic bps_start,
    output logic clk_bps
);
    // Rounded up so the bit period is never shorter than nominal.
    localparam int BPS_CNT = (CLK_FREQ + BAUD - 1) / BAUD;
    localparam int CW      = $clog2(BPS_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(BPS_CNT - 1);

    logic [CW-1:0] cnt_reg;
    logic          clk_bps_reg;

    always_ff @(posedge clk) begin
        if (rst || !bps_start) begin
            cnt_reg     <= '0;
            clk_bps_reg <= 1'b0;
        end else begin
            clk_bps_reg <= (cnt_reg == CNT_MAX);
            if (cnt_reg == CNT_MAX) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign clk_bps = clk_bps_reg;

endmodule

module uart_tx_frame #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       clk_bps,
    output logic       bps_start,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARM   = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] PAR   = 3'd4;
    localparam logic [2:0] STOP  = 3'd5;

    localparam logic [2:0] LAST_DATA  = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP  = 3'(STOP_BITS - 1);
    localparam bit         HAS_PARITY = (PARITY != 0);
    localparam bit         ODD_PARITY = (PARITY == 1);

    logic [2:0] state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic       parity_reg, parity_next;
    logic       uart_tx_reg, uart_tx_next;
    logic       bps_start_reg, bps_start_next;
    logic       tx_busy_reg, tx_busy_next;
    logic       tx_ready_reg, tx_ready_next;
    logic       tx_done_reg, tx_done_next;

    logic [7:0] data_mask;
    logic [7:0] data_masked;
    logic       data_xor;
    logic       parity_calc;
    logic       accept;

    // Bits at or above DATA_BITS are dropped before they reach the shifter or parity.
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
        assign data_mask[gi] = (gi < DATA_BITS) ? 1'b1 : 1'b0;
    end

    assign data_masked = tx_data & data_mask;
    assign data_xor    = ^data_masked;
    assign parity_calc = ODD_PARITY ? ~data_xor : data_xor;
    assign accept      = tx_valid && tx_ready_reg;

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        parity_next    = parity_reg;
        uart_tx_next   = uart_tx_reg;
        bps_start_next = bps_start_reg;
        tx_busy_next   = tx_busy_reg;
        tx_ready_next  = tx_ready_reg;
        tx_done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                uart_tx_next = 1'b1;
                // clk_bps is deliberately not looked at here, even on the acceptance edge.
                if (accept) begin
                    state_next     = ARM;
                    shift_next     = data_masked;
                    parity_next    = parity_calc;
                    bit_cnt_next   = 3'd0;
                    bps_start_next = 1'b1;
                    tx_busy_next   = 1'b1;
                    tx_ready_next  = 1'b0;
                end
            end
            ARM: begin
                if (clk_bps) begin
                    state_next   = START;
                    uart_tx_next = 1'b0;
                end
            end
            START: begin
                if (clk_bps) begin
                    state_next   = DATA;
                    uart_tx_next = shift_reg[0];
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_cnt_next = 3'd0;
                end
            end
            DATA: begin
                if (clk_bps) begin
                    if (bit_cnt_reg == LAST_DATA) begin
                        bit_cnt_next = 3'd0;
                        if (HAS_PARITY) begin
                            state_next   = PAR;
                            uart_tx_next = parity_reg;
                        end else begin
                            state_next   = STOP;
                            uart_tx_next = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        uart_tx_next = shift_reg[0];
                        shift_next   = {1'b0, shift_reg[7:1]};
                    end
                end
            end
            PAR: begin
                if (clk_bps) begin
                    state_next   = STOP;
                    uart_tx_next = 1'b1;
                    bit_cnt_next = 3'd0;
                end
            end
            STOP: begin
                uart_tx_next = 1'b1;
                if (clk_bps) begin
                    if (bit_cnt_reg == LAST_STOP) begin
                        // Ready rises with done so a waiting byte is taken on the very next edge.
                        state_next     = IDLE;
                        bit_cnt_next   = 3'd0;
                        bps_start_next = 1'b0;
                        tx_busy_next   = 1'b0;
                        tx_ready_next  = 1'b1;
                        tx_done_next   = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
            default: begin
                state_next     = IDLE;
                bit_cnt_next   = 3'd0;
                uart_tx_next   = 1'b1;
                bps_start_next = 1'b0;
                tx_busy_next   = 1'b0;
                tx_ready_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'd0;
            parity_reg    <= 1'b0;
            uart_tx_reg   <= 1'b1;
            bps_start_reg <= 1'b0;
            tx_busy_reg   <= 1'b0;
            tx_ready_reg  <= 1'b1;
            tx_done_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            parity_reg    <= parity_next;
            uart_tx_reg   <= uart_tx_next;
            bps_start_reg <= bps_start_next;
            tx_busy_reg   <= tx_busy_next;
            tx_ready_reg  <= tx_ready_next;
            tx_done_reg   <= tx_done_next;
        end
    end

    assign uart_tx   = uart_tx_reg;
    assign bps_start = bps_start_reg;
    assign tx_busy   = tx_busy_reg;
    assign tx_ready  = tx_ready_reg;
    assign tx_done   = tx_done_reg;

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmit framer that sits directly downstream of the baud-rate generator.
- Accepts one byte per valid/ready handshake, raises bps_start to run the generator, and shifts a serial frame out LSB first.
- Frame format is start bit, DATA_BITS data bits, optional parity bit, then STOP_BITS stop bits.
- Each line transition is timed by one clk_bps pulse from the generator; the block has no baud counter of its own.

Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- PARITY, 0: 0 = no parity, 1 = odd parity, 2 = even parity.
- STOP_BITS, 1: number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock (25 MHz); all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send; bits above DATA_BITS-1 are ignored.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a byte.
- clk_bps  input  1  one-cycle bit-timing pulse from the baud generator.
- bps_start  output  1  enables the baud generator; high for the whole frame.
- uart_tx  output  1  serial line; idle level is high.
- tx_busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Clocking and reset: rst is synchronous and active-high; the block uses the single clock clk.
- Reset values: uart_tx=1, bps_start=0, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, bit counter=0.
- Handshake: a byte is accepted on an edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register and parity is computed over DATA_BITS bits at that edge.
  - tx_ready is high only in IDLE and drops on the edge after acceptance.
  - tx_valid while not ready is ignored; it is neither queued nor an error.
- bps_start and tx_busy go high on the edge after acceptance (1-cycle latency) and stay high until the frame ends.
- clk_bps handling: clk_bps is sampled on clk. Every edge at which clk_bps=1 is seen advances the state machine and updates uart_tx on that same edge.
  - clk_bps is ignored in IDLE.
  - clk_bps is ignored on the acceptance edge.
- States:
  - IDLE: uart_tx=1. On acceptance go to ARM.
  - ARM: bps_start=1, uart_tx=1. On clk_bps go to START and drive uart_tx=0.
  - START: on clk_bps go to DATA, drive data bit 0, bit counter=0.
  - DATA: on clk_bps either drive the next bit and increment the counter, or after bit DATA_BITS-1 go to PAR if PARITY!=0, else to STOP.
    - In PAR, uart_tx carries the parity bit: odd parity means data^parity has odd weight; even parity means even weight.
  - PAR: on clk_bps go to STOP and drive uart_tx=1.
  - STOP: uart_tx=1. Each clk_bps counts one stop bit. On the clk_bps that ends stop bit number STOP_BITS:
    - go to IDLE;
    - drive bps_start=0 and tx_busy=0;
    - pulse tx_done=1 for that one cycle;
    - drive tx_ready=1 from the same edge.
- Frame length: the line holds each bit for exactly one clk_bps interval.
  - Total pulses consumed = 2 + DATA_BITS + (PARITY!=0) + STOP_BITS. The default is 11, including the ARM pulse.
  - At 9600 baud and 25 MHz, one bit = 2605 clk.
- Back-to-back frames: a byte offered on the tx_done cycle is accepted there and starts a new ARM. bps_start then drops for exactly one cycle, which restarts the generator phase.
- Simultaneous events:
  - rst wins over everything.
  - tx_valid arriving with clk_bps in IDLE is accepted normally, and that clk_bps is ignored.
- Reset mid-frame: the next edge forces the reset values. The line returns high immediately; a truncated frame on the line is acceptable. No byte is retained.
- clk_bps held high for several cycles: each high cycle counts as a pulse. The generator guarantees single-cycle pulses; this is not filtered.

Test Plan:
- Defaults; the bench drives clk_bps as a 1-cycle pulse every 16 clk; send 0xA5 -> uart_tx sequence after ARM is 0,1,0,1,0,0,1,0,1,1, each bit 16 clk; tx_done once; 11 pulses consumed; bps_start high from acceptance+1 to done.
- PARITY=2, send 0x07 -> parity bit 1; PARITY=1, send 0x07 -> parity bit 0; DATA_BITS=7 with STOP_BITS=2, send 0xFF -> 7 ones then parity then two stop bits; tx_data[7] is never sent.
- Send 0x55 and 0x3C back-to-back, with tx_valid held high through tx_done -> second byte accepted on the tx_done edge; bps_start low for exactly 1 cycle; both frames correct.
- Assert tx_valid with 0x12 while busy -> ignored; tx_ready stays 0; frame in progress unchanged.
- Assert rst during data bit 3 -> next edge gives uart_tx=1, bps_start=0, tx_ready=1, tx_busy=0; no tx_done; next byte 0x81 sends a clean frame.
- Real baud-generator instance at 9600 baud: send 0x00 -> start through the last data bit is 9 × 2605 clk of low line, then a high stop bit of 2605 clk.
